// File: rtl/up_down_dir_decoder.sv
// rtl/up_down_dir_decoder.sv - reconstructs up/down direction and step events from a sampled counter value.
// Optional saturating wrap counter compiled in with macro UP_DOWN_DIR_WRAP_COUNT_EN.
module up_down_dir_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic             up_down_est,
  output logic             step_up,
  output logic             step_down,
  output logic             wrap_pulse,
  output logic             err_jump,
  output logic             err_sticky,
  output logic [7:0]       run_len,
  output logic [2:0]       state,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [2:0] {
    NO_REF = 3'd0,
    HOLD   = 3'd1,
    UP     = 3'd2,
    DOWN   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] prev, prev_n;
  logic [WIDTH-1:0] delta;
  logic             is_up, is_down, is_hold, is_jump;
  logic             est_n, su_n, sd_n, wrap_n, ej_n, sticky_n;
  logic [7:0]       run_n;

  // With WIDTH=1 the +1 and -1 deltas coincide, so up takes precedence.
  assign delta   = count_in - prev;
  assign is_up   = (delta == ONE);
  assign is_down = !is_up && (delta == MAXV);
  assign is_hold = (delta == '0);
  assign is_jump = !(is_up || is_down || is_hold);

  always_ff @(posedge clk) begin
    if (reset) cur_state <= NO_REF;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (count_valid) begin
      if (cur_state == NO_REF)  nxt_state = HOLD;
      else if (is_up)           nxt_state = UP;
      else if (is_down)         nxt_state = DOWN;
      else if (is_jump)         nxt_state = ERROR;
    end
  end

  always_comb begin
    prev_n   = prev;
    est_n    = up_down_est;
    su_n     = 1'b0;
    sd_n     = 1'b0;
    wrap_n   = 1'b0;
    ej_n     = 1'b0;
    sticky_n = err_sticky;
    run_n    = run_len;
    if (count_valid) begin
      prev_n = count_in;
      if (cur_state != NO_REF) begin
        if (is_up) begin
          su_n   = 1'b1;
          est_n  = 1'b1;
          wrap_n = (prev == MAXV);
          run_n  = (cur_state == UP) ? ((run_len == 8'hff) ? run_len : run_len + 8'd1) : 8'd1;
        end else if (is_down) begin
          sd_n   = 1'b1;
          est_n  = 1'b0;
          wrap_n = (prev == '0);
          run_n  = (cur_state == DOWN) ? ((run_len == 8'hff) ? run_len : run_len + 8'd1) : 8'd1;
        end else if (is_jump) begin
          ej_n     = 1'b1;
          sticky_n = 1'b1;
          run_n    = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= '0;
      up_down_est <= 1'b1;
      step_up     <= 1'b0;
      step_down   <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_jump    <= 1'b0;
      err_sticky  <= 1'b0;
      run_len     <= 8'd0;
    end else begin
      prev        <= prev_n;
      up_down_est <= est_n;
      step_up     <= su_n;
      step_down   <= sd_n;
      wrap_pulse  <= wrap_n;
      err_jump    <= ej_n;
      err_sticky  <= sticky_n;
      run_len     <= run_n;
    end
  end

  assign state = cur_state;

`ifdef UP_DOWN_DIR_WRAP_COUNT_EN
  logic [7:0] wrap_q;
  always_ff @(posedge clk) begin
    if (reset)                         wrap_q <= 8'd0;
    else if (wrap_n && wrap_q != 8'hff) wrap_q <= wrap_q + 8'd1;
  end
  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_up_down_dir_decoder.sv
// tb/tb_up_down_dir_decoder.sv - scoreboard bench for up_down_dir_decoder with a behavioural model.
module tb_up_down_dir_decoder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] count_in = '0;
  logic         count_valid = 1'b0;
  logic         up_down_est, step_up, step_down, wrap_pulse, err_jump, err_sticky;
  logic [7:0]   run_len, wrap_cnt;
  logic [2:0]   state;

  up_down_dir_decoder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
    .up_down_est(up_down_est), .step_up(step_up), .step_down(step_down),
    .wrap_pulse(wrap_pulse), .err_jump(err_jump), .err_sticky(err_sticky),
    .run_len(run_len), .state(state), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int est, su, sd, wp, ej, es, run, st, wc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: history-based, with the state number derived from it.
  bit m_ref, m_err;
  int m_prev, m_dir, m_run, m_est, m_sticky, m_wraps;

  task automatic model_reset();
    m_ref = 0; m_err = 0; m_prev = 0; m_dir = 0; m_run = 0;
    m_est = 1; m_sticky = 0; m_wraps = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input int c);
    exp_t e;
    int d;
    @(negedge clk);
    reset = rst; count_valid = v; count_in = W'(c);
    @(posedge clk);
    e = '{est:0, su:0, sd:0, wp:0, ej:0, es:0, run:0, st:0, wc:0};
    if (rst) begin
      model_reset();
    end else if (v) begin
      if (!m_ref) begin
        m_ref = 1;
      end else begin
        d = ((c - m_prev) % M + M) % M;
        if (d == 1) begin
          e.su = 1; m_est = 1;
          e.wp = (m_prev == M - 1 && c == 0);
          m_run = (!m_err && m_dir == 1) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
          m_dir = 1; m_err = 0;
        end else if (d == M - 1) begin
          e.sd = 1; m_est = 0;
          e.wp = (m_prev == 0 && c == M - 1);
          m_run = (!m_err && m_dir == -1) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
          m_dir = -1; m_err = 0;
        end else if (d != 0) begin
          e.ej = 1; m_sticky = 1; m_run = 0; m_dir = 0; m_err = 1;
        end
      end
      m_prev = c;
    end
`ifdef UP_DOWN_DIR_WRAP_COUNT_EN
    if (e.wp && m_wraps < 255) m_wraps++;
`endif
    e.est = m_est; e.es = m_sticky; e.run = m_run; e.wc = m_wraps;
    e.st = !m_ref ? 0 : m_err ? 4 : (m_dir == 1) ? 2 : (m_dir == -1) ? 3 : 1;
    sb.push_back(e);
  endtask

  task automatic seq(input int vals[$]);
    foreach (vals[i]) step(0, 1, vals[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state",       state,       e.st);
        chk("step_up",     step_up,     e.su);
        chk("step_down",   step_down,   e.sd);
        chk("wrap_pulse",  wrap_pulse,  e.wp);
        chk("err_jump",    err_jump,    e.ej);
        chk("err_sticky",  err_sticky,  e.es);
        chk("up_down_est", up_down_est, e.est);
        chk("run_len",     run_len,     e.run);
        chk("wrap_cnt",    wrap_cnt,    e.wc);
      end
    end
  end

  initial begin : driver
    int cur, r, drain;
    model_reset();
    step(1, 1, 7);
    step(1, 0, 0);
    seq('{0, 1, 2, 3});
    step(1, 0, 0);
    seq('{14, 15, 0, 1});
    step(1, 0, 0);
    seq('{5, 4, 3, 4});
    step(1, 0, 0);
    seq('{3, 4, 9, 10});
    step(1, 0, 0);
    seq('{2, 3});
    repeat (5) step(0, 0, $urandom_range(0, 15));
    seq('{4});
    // reset mid-stream with a coinciding sample, then a fresh reference
    seq('{5, 6});
    step(1, 1, 7);
    seq('{8, 9});
    // long runs to saturate run_len and the wrap counter
    cur = 0;
    for (int i = 0; i < 4200; i++) begin
      step(0, 1, cur);
      cur = (cur + 1) % M;
    end
    for (int i = 0; i < 300; i++) begin
      cur = (cur + M - 1) % M;
      step(0, 1, cur);
    end
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, M - 1));
      end else if (r < 15) begin
        step(0, 0, $urandom_range(0, M - 1));
      end else begin
        if (r < 45)      cur = (cur + 1) % M;
        else if (r < 75) cur = (cur + M - 1) % M;
        else if (r < 88) cur = cur;
        else             cur = $urandom_range(0, M - 1);
        step(0, 1, cur);
      end
    end
    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_down_dir_decoder.md
UP_DOWN_DIR_DECODER -- requirements
Module: up_down_dir_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the observed count.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port count_in  input  WIDTH  count value driven by the up/down counter being observed.
REQ-005 SHALL have port count_valid  input  1  count_in is sampled only on edges where this is 1.
REQ-006 SHALL have port up_down_est  output  1  reconstructed counter direction control (1 = up, 0 = down).
REQ-007 SHALL have port step_up  output  1  one-cycle pulse: last sample advanced by +1.
REQ-008 SHALL have port step_down  output  1  one-cycle pulse: last sample advanced by -1.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse: last step crossed max->0 or 0->max.
REQ-010 SHALL have port err_jump  output  1  one-cycle pulse: last sample changed by neither 0 nor +/-1.
REQ-011 SHALL have port err_sticky  output  1  set on any err_jump, cleared only by reset.
REQ-012 SHALL have port run_len  output  8  consecutive steps in current direction.
REQ-013 SHALL have port state  output  3  encoded FSM state.
REQ-014 SHALL have port wrap_cnt  output  8  number of wraps observed (see Configuration).

Function
REQ-015 SHALL register prev (WIDTH bits) holding the last sampled count_in; prev loads on every valid sample.
REQ-016 SHALL compute delta = (count_in - prev) mod 2^WIDTH; delta 1 = up, delta all-ones = down, delta 0 = hold, else jump.
REQ-017 SHALL have FSM states NO_REF=0, HOLD=1, UP=2, DOWN=3, ERROR=4.
REQ-018 SHALL leave NO_REF on the first valid sample, going to HOLD, loading prev, raising no pulses.
REQ-019 SHALL from HOLD/UP/DOWN/ERROR move to UP on up, DOWN on down, ERROR on jump; hold keeps UP/DOWN/ERROR and goes HOLD only from HOLD.
REQ-020 SHALL update all outputs with latency one: sample on edge N is reflected after edge N.
REQ-021 SHALL clear step_up, step_down, wrap_pulse, err_jump on every edge without a qualifying valid sample.
REQ-022 SHALL set up_down_est 1 on up step, 0 on down step, unchanged on hold or jump.
REQ-023 SHALL raise wrap_pulse with step_up when prev=2^WIDTH-1 and count_in=0, and with step_down when prev=0 and count_in=2^WIDTH-1.
REQ-024 SHALL set run_len to 1 on a step opposite to the previous step direction or the first step after NO_REF/ERROR, increment on same-direction step, saturate at 255, hold on hold, clear to 0 on jump.
REQ-025 SHALL keep all state unchanged when count_valid=0 (gaps are not holds).
REQ-026 SHALL treat WIDTH=1 as delta 1 = up only (up and down indistinguishable; down never reported).

Reset
REQ-027 SHALL on reset=1 at a rising edge set state=NO_REF, prev=0, up_down_est=1, run_len=0, wrap_cnt=0, err_sticky=0, all pulses 0.
REQ-028 SHALL give reset priority over count_valid; a sample coinciding with reset is discarded.
REQ-029 SHALL after reset mid-stream require a fresh first sample (NO_REF) before reporting any step.

Configuration
REQ-030 SHALL compile a saturating wrap counter only when macro UP_DOWN_DIR_WRAP_COUNT_EN is defined.
REQ-031 SHALL with UP_DOWN_DIR_WRAP_COUNT_EN increment wrap_cnt on each wrap_pulse, saturating at 255.
REQ-032 SHALL without UP_DOWN_DIR_WRAP_COUNT_EN drive wrap_cnt constant 0; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, valid samples 0,1,2,3 -> state NO_REF,HOLD,UP,UP,UP; step_up pulses on samples 2-4; run_len 3; up_down_est 1.
REQ-034 SHALL cover: samples 14,15,0,1 (WIDTH=4) -> wrap_pulse only after sample 0; wrap_cnt 1 with macro, 0 without.
REQ-035 SHALL cover: samples 5,4,3 then 4 -> step_down x2, up_down_est 0, run_len 2, then step_up, run_len 1, up_down_est 1.
REQ-036 SHALL cover: samples 3,4,9 -> err_jump pulse after 9, state ERROR, err_sticky 1, run_len 0; then 10 -> UP, err_sticky still 1.
REQ-037 SHALL cover: samples 2,3 with count_valid=0 for 5 cycles then 4 -> no pulses during gap, step_up after 4, run_len 2.
REQ-038 SHALL cover: reset asserted with count_valid=1, count_in=7 mid-stream -> all outputs at reset values, next sample produces no step.
